// File: rtl/pattern_sequencer_if.sv
// rtl/pattern_sequencer_if.sv - video timing / pattern bus between a timing source and the sequencer
//
// Purpose: bundles the pixel timing inputs, the generator colour bus and the
// sequencer's selection/colour outputs.
// Signals:
//   x, y            current pixel column / row
//   active          visible-area flag
//   vsync           vertical sync, active low
//   pattern_rgb     all generator outputs, pattern k at [k*RGB_W +: RGB_W]
//   pattern_select  index of the current pattern
//   pattern_enable  one-hot of pattern_select
//   blanking        high while forced-black frames are being output
//   rgb             muxed colour output
// Modports: master drives timing and generator colours, slave is the sequencer.
interface pattern_sequencer_if #(
  parameter int NUM_PATTERNS = 4,
  parameter int SEL_W        = 2,
  parameter int RGB_W        = 6
);
  logic [9:0]                    x;
  logic [9:0]                    y;
  logic                          active;
  logic                          vsync;
  logic [NUM_PATTERNS*RGB_W-1:0] pattern_rgb;
  logic [SEL_W-1:0]              pattern_select;
  logic [NUM_PATTERNS-1:0]       pattern_enable;
  logic                          blanking;
  logic [RGB_W-1:0]              rgb;

  modport master (
    output x, y, active, vsync, pattern_rgb,
    input  pattern_select, pattern_enable, blanking, rgb
  );

  modport slave (
    input  x, y, active, vsync, pattern_rgb,
    output pattern_select, pattern_enable, blanking, rgb
  );
endinterface

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - sequences NUM_PATTERNS generators onto the rgb bus
//
// Purpose: selects one of NUM_PATTERNS pattern generators. Switches come from
// an auto-advance dwell counter or from next/prev requests; each switch waits
// for the frame origin and is followed by BLANK_FRAMES of black output.
// Ports:
//   clk                 pixel clock
//   rst_n               synchronous active-low reset
//   bus                 pattern_sequencer_if.slave (timing in, selection/rgb out)
//   auto_en             1 = auto-advance enabled
//   frames_per_pattern  dwell in frames; 0 selects DEFAULT_FRAMES
//   btn_next            one-cycle request to advance
//   btn_prev            one-cycle request to step back
module pattern_sequencer #(
  parameter int NUM_PATTERNS   = 4,
  parameter int SEL_W          = 2,
  parameter int FRAME_CNT_W    = 8,
  parameter int DEFAULT_FRAMES = 240,
  parameter int BLANK_FRAMES   = 2,
  parameter int RGB_W          = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pattern_sequencer_if.slave     bus,
  input  logic                   auto_en,
  input  logic [FRAME_CNT_W-1:0] frames_per_pattern,
  input  logic                   btn_next,
  input  logic                   btn_prev
);

  typedef enum logic [1:0] {SHOW, PENDING, BLANK} state_t;
  typedef enum logic {DIR_NEXT, DIR_PREV} dir_t;

  localparam logic [SEL_W-1:0]       LAST_SEL   = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [SEL_W:0]         NUM_P      = (SEL_W + 1)'(NUM_PATTERNS);
  localparam logic [FRAME_CNT_W-1:0] DEF_DUR    = FRAME_CNT_W'(DEFAULT_FRAMES);
  // Unused when blanking is disabled; kept legal so the compare stays well formed.
  localparam logic [FRAME_CNT_W-1:0] BLANK_LAST = FRAME_CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  state_t                 state_q, state_d;
  dir_t                   dir_q, dir_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_PATTERNS-1:0] en_q, en_d;
  logic                   blank_q, blank_d;
  logic                   vsync_q;

  logic                   frame_tick;
  logic                   at_origin;
  logic                   single_btn;
  logic [FRAME_CNT_W-1:0] dur;

  assign frame_tick = bus.vsync & ~vsync_q;
  assign at_origin  = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign single_btn = btn_next ^ btn_prev;
  assign dur        = (frames_per_pattern == '0) ? DEF_DUR : frames_per_pattern;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHOW;
      dir_q   <= DIR_NEXT;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= NUM_PATTERNS'(1);
      blank_q <= 1'b0;
      vsync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      blank_q <= blank_d;
      vsync_q <= bus.vsync;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      SHOW: begin
        if (auto_en) begin
          if (frame_tick) begin
            // >= rather than == so a dwell shortened below the count still fires.
            if (cnt_q >= dur - 1'b1) begin
              cnt_d   = '0;
              dir_d   = DIR_NEXT;
              state_d = PENDING;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else begin
          cnt_d = '0;
        end
        // A button overrides the auto-advance direction in the same cycle.
        if (single_btn) begin
          dir_d   = btn_prev ? DIR_PREV : DIR_NEXT;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (single_btn) begin
          dir_d = btn_prev ? DIR_PREV : DIR_NEXT;
        end
        if (at_origin) begin
          if (dir_d == DIR_NEXT) begin
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
          end else begin
            sel_d = (sel_q == '0) ? LAST_SEL : sel_q - 1'b1;
          end
          cnt_d   = '0;
          state_d = (BLANK_FRAMES > 0) ? BLANK : SHOW;
        end
      end
      BLANK: begin
        if (frame_tick) begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Enable follows the new select from the switch edge, so the incoming
  // generator is already running while the output is blanked.
  always_comb begin
    en_d = '0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      en_d[k] = (sel_d == SEL_W'(k));
    end
    blank_d = (state_d == BLANK);
  end

  logic [RGB_W-1:0] rgb_c;

  always_comb begin
    rgb_c = '0;
    if (!blank_q && bus.active && ({1'b0, sel_q} < NUM_P)) begin
      rgb_c = bus.pattern_rgb[sel_q*RGB_W +: RGB_W];
    end
  end

  assign bus.pattern_select = sel_q;
  assign bus.pattern_enable = en_q;
  assign bus.blanking       = blank_q;
  assign bus.rgb            = rgb_c;

endmodule
